// File: rtl/bram_stream_loader.sv
// Framed byte-stream loader: assembles little-endian words and writes them to one BRAM port.
// Define BRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module bram_stream_loader #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDRESS_WIDTH-1:0] avm_address,
  output logic [3:0]               avm_byteenable,
  output logic                     avm_write,
  output logic [31:0]              avm_writedata,
  output logic                     avm_read,
  output logic                     core_reset,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE
`ifdef BRAM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic [ADDRESS_WIDTH-1:0] avm_address_q, avm_address_d;
  logic                     avm_write_q, avm_write_d;
  logic [31:0]              avm_writedata_q, avm_writedata_d;
  logic                     core_reset_q, core_reset_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [7:0]               addr_hi_q, addr_hi_d;
  logic [7:0]               len_hi_q, len_hi_d;
  logic [15:0]              remaining_q, remaining_d;
  logic [1:0]               lane_q, lane_d;
  logic [23:0]              word_q, word_d;
  logic                     xfer;
  logic                     finish;
`ifdef BRAM_LOADER_CHECKSUM_EN
  logic                     error_q, error_d;
  logic [7:0]               csum_q, csum_d;
`endif

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d         = state_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    avm_write_d     = 1'b0;
    core_reset_d    = core_reset_q;
    done_d          = 1'b0;
    addr_hi_d       = addr_hi_q;
    len_hi_d        = len_hi_q;
    remaining_d     = remaining_q;
    lane_d          = lane_q;
    word_d          = word_q;
    finish          = 1'b0;
`ifdef BRAM_LOADER_CHECKSUM_EN
    error_d         = 1'b0;
    csum_d          = csum_q;
`endif
    case (state_q)
      S_SYNC: if (xfer && in_data == SYNC_BYTE) begin
        state_d      = S_ADDR_HI;
        core_reset_d = 1'b1;
        lane_d       = '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
        csum_d       = '0;
`endif
      end
      S_ADDR_HI: if (xfer) begin
        addr_hi_d = in_data;
        state_d   = S_ADDR_LO;
      end
      S_ADDR_LO: if (xfer) begin
        avm_address_d = ADDRESS_WIDTH'({addr_hi_q, in_data});
        state_d       = S_LEN_HI;
      end
      S_LEN_HI: if (xfer) begin
        len_hi_d = in_data;
        state_d  = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        remaining_d = {len_hi_q, in_data};
        if ({len_hi_q, in_data} == 16'd0) finish = 1'b1;
        else state_d = S_DATA;
      end
      // Bytes shift in from the top, so after four the first byte sits in lane 0.
      S_DATA: if (xfer) begin
        word_d = {in_data, word_q[23:8]};
        lane_d = lane_q + 2'd1;
`ifdef BRAM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ in_data;
`endif
        if (lane_q == 2'd3) begin
          state_d         = S_WRITE;
          avm_write_d     = 1'b1;
          avm_writedata_d = {in_data, word_q};
        end
      end
      S_WRITE: begin
        avm_address_d = avm_address_q + ADDRESS_WIDTH'(1);
        remaining_d   = remaining_q - 16'd1;
        if (remaining_q == 16'd1) finish = 1'b1;
        else state_d = S_DATA;
      end
`ifdef BRAM_LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) begin
        if (in_data == csum_q) done_d = 1'b1;
        else error_d = 1'b1;
        core_reset_d = 1'b0;
        state_d      = S_SYNC;
      end
`endif
      default: state_d = S_SYNC;
    endcase

    if (finish) begin
`ifdef BRAM_LOADER_CHECKSUM_EN
      state_d      = S_CSUM;
`else
      state_d      = S_SYNC;
      done_d       = 1'b1;
      core_reset_d = 1'b0;
`endif
    end
  end

  assign in_ready_d = (state_d != S_WRITE);
  assign busy_d     = (state_d != S_SYNC);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_SYNC;
      in_ready_q      <= 1'b1;
      avm_address_q   <= '0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
      core_reset_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_hi_q       <= '0;
      len_hi_q        <= '0;
      remaining_q     <= '0;
      lane_q          <= '0;
      word_q          <= '0;
`ifdef BRAM_LOADER_CHECKSUM_EN
      error_q         <= 1'b0;
      csum_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      in_ready_q      <= in_ready_d;
      avm_address_q   <= avm_address_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
      core_reset_q    <= core_reset_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      addr_hi_q       <= addr_hi_d;
      len_hi_q        <= len_hi_d;
      remaining_q     <= remaining_d;
      lane_q          <= lane_d;
      word_q          <= word_d;
`ifdef BRAM_LOADER_CHECKSUM_EN
      error_q         <= error_d;
      csum_q          <= csum_d;
`endif
    end
  end

  assign in_ready       = in_ready_q;
  assign avm_address    = avm_address_q;
  assign avm_byteenable = 4'hF;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_read       = 1'b0;
  assign core_reset     = core_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef BRAM_LOADER_CHECKSUM_EN
  assign error          = error_q;
`else
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader against a frame-level reference model.
module tb_bram_stream_loader;

  localparam int unsigned AW = 12;
  typedef logic [7:0] bytes_t[$];

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic          avm_read;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;

  int total = 0;
  int bad = 0;

  bram_stream_loader #(.ADDRESS_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Observation side: write log, pulse counts and the in_ready/WRITE relation.
  int unsigned   cyc = 0;
  bit            mon_en = 1'b0;
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  int unsigned   done_cnt = 0;
  int unsigned   err_cnt = 0;
  int unsigned   ready_bad = 0;
  int unsigned   last_wr_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (avm_write === 1'b1) begin
        obs_addr.push_back(avm_address);
        obs_data.push_back(avm_writedata);
        last_wr_cyc = cyc;
      end
      if (done === 1'b1) done_cnt++;
      if (error === 1'b1) err_cnt++;
      if (in_ready !== ~avm_write) ready_bad++;
    end
  end

  function automatic bytes_t rand_bytes(input int unsigned n);
    bytes_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int unsigned n;
    in_data  = b;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, n);
    end
    if (gaps && $urandom_range(3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(3, 1)) @(posedge clock);
      #1;
    end
  endtask

  // Sends one frame and checks writes, pulses and handshake against the model.
  task automatic run_frame(input logic [15:0] addr, input bytes_t d, input bit gaps,
                           input bit corrupt, input bit b2b, input string tag);
    int unsigned len, o0, done0, err0, rb0, first_cyc, exp_done, exp_err;
    logic [7:0]    cs;
    logic [AW-1:0] ea;
    logic [31:0]   ew;
    len = d.size() / 4;
    cs = '0;
    foreach (d[i]) cs ^= d[i];
    o0 = obs_addr.size(); done0 = done_cnt; err0 = err_cnt; rb0 = ready_bad;
    first_cyc = 0;

    send_byte(8'hA5, gaps);
    total++;
    if (core_reset !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_frame_start: core_reset=%b busy=%b want 1 1", tag, core_reset, busy);
    end
    send_byte(addr[15:8], gaps);
    send_byte(addr[7:0], gaps);
    send_byte(8'(len >> 8), gaps);
    send_byte(8'(len), gaps);
    foreach (d[i]) begin
      send_byte(d[i], gaps);
      if (i == 0) first_cyc = cyc;
    end
`ifdef BRAM_LOADER_CHECKSUM_EN
    send_byte(corrupt ? (cs ^ 8'h5A) : cs, gaps);
`endif
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;

`ifdef BRAM_LOADER_CHECKSUM_EN
    exp_done = corrupt ? 0 : 1;
    exp_err  = corrupt ? 1 : 0;
`else
    exp_done = 1;
    exp_err  = 0;
`endif

    total++;
    if (obs_addr.size() - o0 != len) begin
      bad++;
      $display("FAIL %s_write_count: got %0d want %0d", tag, obs_addr.size() - o0, len);
    end else begin
      for (int unsigned i = 0; i < len; i++) begin
        ea = AW'(32'(addr) + i);
        ew = {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]};
        total++;
        if (obs_addr[o0+i] !== ea || obs_data[o0+i] !== ew) begin
          bad++;
          $display("FAIL %s_write%0d: got %h/%h want %h/%h", tag, i,
                   obs_addr[o0+i], obs_data[o0+i], ea, ew);
        end
      end
    end
    total++;
    if (done_cnt - done0 != exp_done || err_cnt - err0 != exp_err) begin
      bad++;
      $display("FAIL %s_pulses: done=%0d error=%0d want %0d %0d", tag,
               done_cnt - done0, err_cnt - err0, exp_done, exp_err);
    end
    total++;
    if (core_reset !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_frame_end: core_reset=%b busy=%b want 0 0", tag, core_reset, busy);
    end
    total++;
    if (ready_bad != rb0) begin
      bad++;
      $display("FAIL %s_ready: in_ready/avm_write disagreements=%0d want 0", tag, ready_bad - rb0);
    end
    if (b2b) begin
      // 5 cycles per word from the first data byte; the last write shows 2 cycles before that span ends.
      total++;
      if (last_wr_cyc - first_cyc != 5 * len - 2) begin
        bad++;
        $display("FAIL %s_throughput: got %0d want %0d", tag, last_wr_cyc - first_cyc, 5 * len - 2);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (in_ready !== 1'b1 || avm_write !== 1'b0 || avm_address !== '0 || avm_writedata !== '0 ||
        core_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b wr=%b a=%h d=%h cr=%b busy=%b done=%b err=%b",
               in_ready, avm_write, avm_address, avm_writedata, core_reset, busy, done, error);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || core_reset !== 1'b0 || avm_write !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: rdy=%b busy=%b cr=%b wr=%b want 1 0 0 0",
               in_ready, busy, core_reset, avm_write);
    end
    total++;
    if (avm_byteenable !== 4'hF || avm_read !== 1'b0) begin
      bad++;
      $display("FAIL constants: be=%h rd=%b want f 0", avm_byteenable, avm_read);
    end
  endtask

  task automatic test_basic();
    bytes_t d;
    int unsigned o0;
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    o0 = obs_data.size();
    send_byte(8'h00, 1'b0);
    total++;
    if (busy !== 1'b0 || core_reset !== 1'b0) begin
      bad++;
      $display("FAIL basic_drop: busy=%b cr=%b want 0 0", busy, core_reset);
    end
    run_frame(16'h0010, d, 1'b0, 1'b0, 1'b0, "basic");
    total++;
    if (obs_data.size() <= o0 || obs_data[o0] !== 32'h44332211) begin
      bad++;
      $display("FAIL basic_word: got %h want 44332211",
               (obs_data.size() > o0) ? obs_data[o0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    run_frame(16'h0FFF, rand_bytes(8), 1'b1, 1'b0, 1'b0, "wrap");
    run_frame(16'hF005, rand_bytes(4), 1'b1, 1'b0, 1'b0, "high_bits");
  endtask

  task automatic test_len_zero();
    run_frame(16'h0123, rand_bytes(0), 1'b0, 1'b0, 1'b0, "len0");
  endtask

  task automatic test_back_to_back();
    run_frame(16'(($urandom_range(4095))), rand_bytes(32), 1'b0, 1'b0, 1'b1, "b2b");
  endtask

  task automatic test_reset_abort();
    bytes_t d;
    int unsigned o0;
    d = rand_bytes(8);
    o0 = obs_addr.size();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(d[0], 1'b0);
    send_byte(d[1], 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    total++;
    if (core_reset !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_state: cr=%b busy=%b rdy=%b want 0 0 1", core_reset, busy, in_ready);
    end
    repeat (6) @(posedge clock);
    #1;
    total++;
    if (obs_addr.size() != o0) begin
      bad++;
      $display("FAIL abort_writes: got %0d want 0", obs_addr.size() - o0);
    end
    run_frame(16'h0240, d, 1'b0, 1'b0, 1'b0, "resend");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_frame(16'($urandom), rand_bytes(4 * $urandom_range(4, 1)), 1'b1, 1'b0, 1'b0, "rand");
  endtask

`ifdef BRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    run_frame(16'h0300, rand_bytes(8), 1'b1, 1'b1, 1'b0, "bad_csum");
    run_frame(16'h0310, rand_bytes(0), 1'b0, 1'b0, 1'b0, "csum_len0");
    run_frame(16'h0320, rand_bytes(4), 1'b0, 1'b0, 1'b0, "good_csum");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
`ifdef BRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
